// File: rtl/hsv_pat_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : hsv_pat_pkg
//  Purpose  : Shared types and widths for the HSV test-pattern generator.
//             Provides the pattern-mode enum, the HSV/coordinate widths and
//             a helper that returns the next pattern in the rotation.
//  Revision : 1.0  initial release
// ============================================================================
package hsv_pat_pkg;

   localparam int HSV_W   = 8;
   localparam int COORD_W = 10;

   typedef enum logic [1:0] {
      MODE_HBAR  = 2'd0,
      MODE_VBAR  = 2'd1,
      MODE_DIAG  = 2'd2,
      MODE_SOLID = 2'd3
   } mode_e;

   // Rotation order HBAR -> VBAR -> DIAG -> SOLID -> HBAR
   function automatic mode_e mode_succ(input mode_e m);
      mode_e r;
      case (m)
         MODE_HBAR : r = MODE_VBAR;
         MODE_VBAR : r = MODE_DIAG;
         MODE_DIAG : r = MODE_SOLID;
         default   : r = MODE_HBAR;
      endcase
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/hsv_sync_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : hsv_sync_pipe
//  Purpose  : Resettable shift register delaying a BITS-wide bus by DELAY
//             clocks. Each bit has its own reset value (RST_VAL) so that
//             active-low syncs can reset to their inactive level.
//  Ports    : clk    - clock
//             rst_n  - asynchronous reset, active-low
//             i_d    - input bus
//             o_q    - i_d delayed by DELAY cycles
//  Revision : 1.0  initial release
// ============================================================================
module hsv_sync_pipe #(
   parameter int              BITS    = 3,
   parameter int              DELAY   = 3,
   parameter logic [BITS-1:0] RST_VAL = '0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [BITS-1:0] i_d,
   output logic [BITS-1:0] o_q
);

   logic [DELAY-1:0][BITS-1:0] r_stage;

   generate
      if (DELAY == 1) begin : g_single
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) r_stage[0] <= RST_VAL;
            else        r_stage[0] <= i_d;
         end
      end else begin : g_multi
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) r_stage <= {DELAY{RST_VAL}};
            else        r_stage <= {r_stage[DELAY-2:0], i_d};
         end
      end
   endgenerate

   assign o_q = r_stage[DELAY-1];

endmodule
`default_nettype wire

// File: rtl/hsv_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module   : hsv_pattern_gen
//  Purpose  : Per-pixel HSV test-pattern source feeding an HSV->RGB
//             converter. Generates one of four hue patterns from the pixel
//             position, scrolls the hue once per frame, and re-times the
//             display syncs to line up with the converter's RGB output.
//  Ports    : clk, rst_n           - pixel clock, async reset (active-low)
//             hsync_i, vsync_i     - timing syncs (active-low)
//             de_i                 - active-video enable
//             sat_i, val_i         - saturation / value during active video
//             mode_next            - pulse: advance pattern at next frame
//             freeze_i             - hold the hue phase
//             h, s, v              - registered HSV to converter
//             hsync_o/vsync_o/de_o - syncs delayed 1+CONV_LATENCY
//  Config   : HSV_PAT_CHECKER_EN   - halves v on a 32x32 checkerboard
//  Revision : 1.0  initial release
// ============================================================================
module hsv_pattern_gen
   import hsv_pat_pkg::*;
#(
   parameter int               H_SHIFT      = 2,
   parameter int               V_SHIFT      = 1,
   parameter logic [HSV_W-1:0] HUE_STEP     = 8'd1,
   parameter int               CONV_LATENCY = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             hsync_i,
   input  logic             vsync_i,
   input  logic             de_i,
   input  logic [HSV_W-1:0] sat_i,
   input  logic [HSV_W-1:0] val_i,
   input  logic             mode_next,
   input  logic             freeze_i,
   output logic [HSV_W-1:0] h,
   output logic [HSV_W-1:0] s,
   output logic [HSV_W-1:0] v,
   output logic             hsync_o,
   output logic             vsync_o,
   output logic             de_o
);

   localparam int              C_SYNC_DELAY = 1 + CONV_LATENCY;
   localparam logic [COORD_W-1:0] C_COORD_MAX = '1;

   logic               r_vsync_prev;
   logic               r_de_prev;
   logic [COORD_W-1:0] r_x;
   logic [COORD_W-1:0] r_y;
   logic [HSV_W-1:0]   r_phase;
   logic               r_pending;
   mode_e              r_mode;
   mode_e              w_mode_nxt;
   logic               w_frame_start;
   logic               w_line_end;
   logic [COORD_W-1:0] w_x_shift;
   logic [COORD_W-1:0] w_y_shift;
   logic [HSV_W-1:0]   w_hue;
   logic [HSV_W-1:0]   w_v_act;
   logic [2:0]         w_sync_q;

   assign w_frame_start = r_vsync_prev & ~vsync_i;
   assign w_line_end    = r_de_prev & ~de_i;

   // ---------------- edge detect history ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vsync_prev <= 1'b1;
         r_de_prev    <= 1'b0;
      end else begin
         r_vsync_prev <= vsync_i;
         r_de_prev    <= de_i;
      end
   end

   // ---------------- pixel coordinates ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_x <= '0;
      end else if (!de_i) begin
         r_x <= '0;
      end else if (r_x != C_COORD_MAX) begin
         r_x <= r_x + 10'd1;
      end
   end

   // frame_start wins over a coincident line_end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_y <= '0;
      end else if (w_frame_start) begin
         r_y <= '0;
      end else if (w_line_end && (r_y != C_COORD_MAX)) begin
         r_y <= r_y + 10'd1;
      end
   end

   // ---------------- hue phase ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_phase <= '0;
      end else if (w_frame_start && !freeze_i) begin
         r_phase <= r_phase + HUE_STEP;
      end
   end

   // ---------------- mode FSM: state register ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mode    <= MODE_HBAR;
         r_pending <= 1'b0;
      end else begin
         r_mode <= w_mode_nxt;
         // Any number of requests within a frame collapse into one step
         if (w_frame_start)  r_pending <= 1'b0;
         else if (mode_next) r_pending <= 1'b1;
      end
   end

   // ---------------- mode FSM: next state ----------------
   always_comb begin
      w_mode_nxt = r_mode;
      if (w_frame_start && (r_pending || mode_next)) begin
         w_mode_nxt = mode_succ(r_mode);
      end
   end

   // ---------------- mode FSM: output (hue select) ----------------
   assign w_x_shift = r_x >> H_SHIFT;
   assign w_y_shift = r_y >> V_SHIFT;

   always_comb begin
      w_hue = r_phase;
      case (r_mode)
         MODE_HBAR : w_hue = w_x_shift[HSV_W-1:0] + r_phase;
         MODE_VBAR : w_hue = w_y_shift[HSV_W-1:0] + r_phase;
         MODE_DIAG : w_hue = w_x_shift[HSV_W-1:0] + w_y_shift[HSV_W-1:0] + r_phase;
         default   : w_hue = r_phase;
      endcase
   end

   // ---------------- value / optional checker overlay ----------------
`ifdef HSV_PAT_CHECKER_EN
   logic w_checker;
   assign w_checker = r_x[5] ^ r_y[5];
   assign w_v_act   = w_checker ? (val_i >> 1) : val_i;
`else
   assign w_v_act   = val_i;
`endif

   // ---------------- registered HSV (black outside active video) ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h <= '0;
         s <= '0;
         v <= '0;
      end else if (de_i) begin
         h <= w_hue;
         s <= sat_i;
         v <= w_v_act;
      end else begin
         h <= '0;
         s <= '0;
         v <= '0;
      end
   end

   // ---------------- sync re-timing ----------------
   hsv_sync_pipe #(
      .BITS    (3),
      .DELAY   (C_SYNC_DELAY),
      .RST_VAL (3'b110)
   ) u_sync_pipe (
      .clk   (clk),
      .rst_n (rst_n),
      .i_d   ({hsync_i, vsync_i, de_i}),
      .o_q   (w_sync_q)
   );

   assign hsync_o = w_sync_q[2];
   assign vsync_o = w_sync_q[1];
   assign de_o    = w_sync_q[0];

endmodule
`default_nettype wire

// File: tb/tb_hsv_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hsv_pattern_gen
//  Purpose  : Self-checking bench for hsv_pattern_gen: table-driven pixel
//             vectors on one line plus directed multi-frame sequences.
//  Revision : 1.0  initial release
// ============================================================================
module tb_hsv_pattern_gen;

`ifdef HSV_PAT_CHECKER_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic       hsync_i, vsync_i, de_i, mode_next, freeze_i;
   logic [7:0] sat_i, val_i;
   logic [7:0] h, s, v;
   logic       hsync_o, vsync_o, de_o;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      int         x;
      logic [7:0] sat;
      logic [7:0] val;
      logic [7:0] eh;
      logic [7:0] es;
      logic [7:0] ev;
   } vec_t;

   vec_t tbl [8];

   hsv_pattern_gen dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .hsync_i   (hsync_i),
      .vsync_i   (vsync_i),
      .de_i      (de_i),
      .sat_i     (sat_i),
      .val_i     (val_i),
      .mode_next (mode_next),
      .freeze_i  (freeze_i),
      .h         (h),
      .s         (s),
      .v         (v),
      .hsync_o   (hsync_o),
      .vsync_o   (vsync_o),
      .de_o      (de_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_line(input int n, input int b);
      sat_i = 8'd255;
      val_i = 8'd255;
      de_i  = 1'b1;
      repeat (n) step();
      de_i = 1'b0;
      repeat (b) step();
   endtask

   task automatic check_line(input int n, input int xc, input int eh, input string name);
      sat_i = 8'd255;
      val_i = 8'd255;
      de_i  = 1'b1;
      for (int p = 0; p < n; p++) begin
         step();
         if (p == xc) chk(name, h, eh);
      end
      de_i = 1'b0;
      repeat (4) step();
   endtask

   // vsync falling edge; mn raises mode_next on the frame_start cycle itself
   task automatic frame(input bit mn);
      de_i      = 1'b0;
      vsync_i   = 1'b0;
      mode_next = mn;
      step();
      mode_next = 1'b0;
      step();
      vsync_i = 1'b1;
      step();
      step();
   endtask

   initial begin
      int k;

      // Line y=0, HBAR, phase 0
      tbl[0] = '{0,   8'd255, 8'd255, 8'd0,   8'd255, 8'd255};
      tbl[1] = '{4,   8'd255, 8'd255, 8'd1,   8'd255, 8'd255};
      tbl[2] = '{5,   8'd10,  8'd20,  8'd1,   8'd10,  8'd20};
      tbl[3] = '{32,  8'd255, 8'd200, 8'd8,   8'd255, CHK ? 8'd100 : 8'd200};
      tbl[4] = '{63,  8'd1,   8'd255, 8'd15,  8'd1,   CHK ? 8'd127 : 8'd255};
      tbl[5] = '{64,  8'd255, 8'd200, 8'd16,  8'd255, 8'd200};
      tbl[6] = '{100, 8'd128, 8'd64,  8'd25,  8'd128, CHK ? 8'd32 : 8'd64};
      tbl[7] = '{639, 8'd255, 8'd255, 8'd159, 8'd255, CHK ? 8'd127 : 8'd255};

      rst_n = 1'b0; hsync_i = 1'b1; vsync_i = 1'b1; de_i = 1'b0;
      sat_i = 8'd0; val_i = 8'd0; mode_next = 1'b0; freeze_i = 1'b0;
      step();
      step();
      chk("rst_h", h, 0);
      chk("rst_hsync_o", hsync_o, 1);
      chk("rst_de_o", de_o, 0);
      rst_n = 1'b1;
      step();

      // ---- reset asserted mid-line acts immediately ----
      de_i = 1'b1; hsync_i = 1'b0; sat_i = 8'd255; val_i = 8'd255;
      repeat (8) step();
      chk("pre_rst_de_o", de_o, 1);
      #3;
      rst_n = 1'b0;
      #1;
      chk("async_rst_h", h, 0);
      chk("async_rst_s", s, 0);
      chk("async_rst_v", v, 0);
      chk("async_rst_hsync_o", hsync_o, 1);
      chk("async_rst_vsync_o", vsync_o, 1);
      chk("async_rst_de_o", de_o, 0);
      de_i = 1'b0; hsync_i = 1'b1;
      step();
      rst_n = 1'b1;
      step();
      step();

      // ---- table-driven line y=0 ----
      k = 0;
      for (int p = 0; p < 640; p++) begin
         if (k < 8 && tbl[k].x == p) begin
            sat_i = tbl[k].sat;
            val_i = tbl[k].val;
         end else begin
            sat_i = 8'd255;
            val_i = 8'd255;
         end
         de_i = 1'b1;
         step();
         if (p < 3) chk($sformatf("de_o_lat_p%0d", p), de_o, (p == 2) ? 1 : 0);
         if (k < 8 && tbl[k].x == p) begin
            chk($sformatf("h_x%0d", p), h, tbl[k].eh);
            chk($sformatf("s_x%0d", p), s, tbl[k].es);
            chk($sformatf("v_x%0d", p), v, tbl[k].ev);
            k++;
         end
      end
      // blanking: black output, delayed de/hsync
      de_i = 1'b0; sat_i = 8'd255; val_i = 8'd255;
      step();
      chk("blank_h", h, 0);
      chk("blank_s", s, 0);
      chk("blank_v", v, 0);
      chk("blank_de_o_still", de_o, 1);
      step();
      step();
      chk("blank_de_o_fall", de_o, 0);
      hsync_i = 1'b0;
      step();
      chk("hsync_o_d1", hsync_o, 1);
      step();
      step();
      chk("hsync_o_d3", hsync_o, 0);
      hsync_i = 1'b1;
      repeat (3) step();

      // ---- line y=1: x saturation ----
      de_i = 1'b1;
      for (int p = 0; p < 1100; p++) begin
         step();
         if (p == 1060) chk("x_saturate", h, 255);
      end
      de_i = 1'b0;
      repeat (4) step();

      // ---- lines y=2..31, then checker probe on y=32 ----
      repeat (30) run_line(40, 4);
      val_i = 8'd200; sat_i = 8'd255; de_i = 1'b1;
      for (int p = 0; p < 40; p++) begin
         step();
         if (p == 0)  chk("v_x0_y32", v, CHK ? 100 : 200);
         if (p == 32) chk("v_x32_y32", v, 200);
         if (p == 32) chk("h_x32_y32", h, 8);
      end
      de_i = 1'b0;
      repeat (4) step();

      // ---- phase scroll / freeze ----
      repeat (3) frame(1'b0);
      check_line(40, 0, 3, "phase_3");
      freeze_i = 1'b1;
      repeat (2) frame(1'b0);
      check_line(40, 0, 3, "phase_frozen");

      // ---- two mode_next pulses mid-frame ----
      de_i = 1'b1; sat_i = 8'd255; val_i = 8'd255;
      for (int p = 0; p < 40; p++) begin
         mode_next = (p == 10 || p == 20);
         step();
      end
      mode_next = 1'b0; de_i = 1'b0;
      repeat (4) step();
      check_line(40, 4, 4, "hbar_hold_midframe");
      frame(1'b0);
      check_line(40, 4, 3, "vbar_after_fs");
      frame(1'b0);
      check_line(40, 8, 3, "vbar_one_step");

      // ---- phase wraps 255 -> 0 ----
      freeze_i = 1'b0;
      repeat (252) frame(1'b0);
      check_line(40, 0, 255, "phase_255");
      frame(1'b0);
      check_line(40, 0, 0, "phase_wrap");
      repeat (9) run_line(40, 4);
      check_line(40, 0, 5, "vbar_y10");

      // ---- mode_next on the frame_start cycle ----
      freeze_i = 1'b1;
      frame(1'b1);
      check_line(40, 8, 2, "diag_y0");
      repeat (3) run_line(40, 4);
      check_line(40, 8, 4, "diag_y4");
      frame(1'b1);
      check_line(200, 100, 0, "solid");
      frame(1'b1);
      check_line(200, 100, 25, "hbar_wrap");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
